// File: rtl/pulse_generator.sv
// Debounced push-button to single-cycle pulse: 2-FF synchronizer, debounce
// counter and rising-edge detector, all cleared by an asynchronous active-low reset.
module pulse_generator #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_WIDTH       = 32,
    parameter bit          IN_ACTIVE_LOW   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic _in,
    output logic _out
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 x;
    logic                 sync1_q;
    logic                 sync2_q;
    logic                 db_q;
    logic                 db_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 out_q;
    logic                 out_d;

    assign x = _in ^ IN_ACTIVE_LOW;

    // NOTE: every path assigns its default first, so no latch is inferred here.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // Pulse only on the edge where the debounced level rises.
        out_d = db_d & ~db_q;
    end

    // NOTE: non-blocking assignments make sync1 -> sync2 a true two-stage shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
            out_q   <= 1'b0;
        end else begin
            sync1_q <= x;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign _out = out_q;

endmodule

// File: tb/tb_pulse_generator.sv
// Randomized and directed bench for pulse_generator; a window-based reference
// model predicts pulse edges into a scoreboard that a monitor drains.
module tb_pulse_generator;

    localparam int D = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn = 1'b1;
    logic pulse;

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    int n_pulses = 0;
    int last_pulse = -1;

    pulse_generator #(
        .DEBOUNCE_CYCLES(D),
        .CNT_WIDTH      (8),
        .IN_ACTIVE_LOW  (1'b0)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        ._in  (btn),
        ._out (pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: the debounced level flips once the last D synchronized
    // samples all disagree with it; a rising flip is an expected pulse edge.
    logic m_p0 = 1'b0;
    logic m_p1 = 1'b0;
    logic m_db = 1'b0;
    logic hist[$];
    int   exp_q[$];

    always @(negedge rst_n) begin
        m_p0 = 1'b0;
        m_p1 = 1'b0;
        m_db = 1'b0;
        hist.delete();
        exp_q.delete();
    end

    always @(posedge clk) begin
        logic flip;
        cyc++;
        if (!rst_n) begin
            m_p0 = 1'b0;
            m_p1 = 1'b0;
            m_db = 1'b0;
            hist.delete();
        end else begin
            hist.push_back(m_p1);
            if (hist.size() > D) void'(hist.pop_front());
            flip = (hist.size() == D);
            foreach (hist[i]) if (hist[i] == m_db) flip = 1'b0;
            if (flip) begin
                m_db = ~m_db;
                hist.delete();
                if (m_db) exp_q.push_back(cyc);
            end
            m_p1 = m_p0;
            m_p0 = btn;
        end
    end

    // Monitor: every observed pulse must match the oldest predicted edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("out_during_reset", int'(pulse), 0);
        end else if (pulse) begin
            n_pulses++;
            last_pulse = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", int'(pulse), 0);
            end else begin
                check("pulse_edge", cyc, exp_q.pop_front());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int p0;
        int t0;
        int rel;
        int db_seen;
        int waited;

        // Reset held 3 cycles with the button already pressed.
        btn   = 1'b1;
        rst_n = 1'b0;
        step(3);
        check("out_at_release", int'(pulse), 0);
        rst_n = 1'b1;
        rel   = cyc;
        p0    = n_pulses;
        step(12);
        check("reset_release_pulses", n_pulses - p0, 1);
        check("reset_release_edge", last_pulse, rel + 6);

        // Clean press.
        btn = 1'b0;
        step(12);
        btn = 1'b1;
        t0  = cyc;
        p0  = n_pulses;
        step(50);
        check("clean_press_pulses", n_pulses - p0, 1);
        check("clean_press_edge", last_pulse, t0 + 6);

        // Bounce 1,0,1,0 every 2 cycles, then stays high.
        btn = 1'b0;
        step(12);
        p0 = n_pulses;
        for (int i = 0; i < 4; i++) begin
            btn = (i % 2 == 0);
            step(2);
        end
        check("bounce_no_pulse", n_pulses - p0, 0);
        btn = 1'b1;
        t0  = cyc;
        step(20);
        check("bounce_pulses", n_pulses - p0, 1);
        check("bounce_edge", last_pulse, t0 + 6);

        // Short glitch: high for 3 cycles only.
        btn = 1'b0;
        step(12);
        p0      = n_pulses;
        db_seen = 0;
        btn     = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (i == 3) btn = 1'b0;
            step(1);
            if (dut.db_q) db_seen = 1;
        end
        check("glitch_db_low", db_seen, 0);
        check("glitch_pulses", n_pulses - p0, 0);

        // Press, release, press again.
        p0  = n_pulses;
        btn = 1'b1;
        step(12);
        btn = 1'b0;
        step(10);
        check("release_no_pulse", n_pulses - p0, 1);
        btn = 1'b1;
        step(12);
        check("repress_pulses", n_pulses - p0, 2);

        // Asynchronous reset while the counter is at 2.
        btn = 1'b0;
        step(12);
        btn    = 1'b1;
        waited = 0;
        while (dut.cnt_q != 2 && waited < 20) begin
            step(1);
            waited++;
        end
        check("cnt_reached_2", int'(dut.cnt_q), 2);
        #2 rst_n = 1'b0;
        #1;
        check("async_cnt", int'(dut.cnt_q), 0);
        check("async_db", int'(dut.db_q), 0);
        check("async_out", int'(pulse), 0);
        check("async_sync", int'({dut.sync1_q, dut.sync2_q}), 0);
        step(2);
        rst_n = 1'b1;
        rel   = cyc;
        p0    = n_pulses;
        step(3);
        check("count_restart", int'(dut.cnt_q), 1);
        step(9);
        check("after_reset_pulses", n_pulses - p0, 1);
        check("after_reset_edge", last_pulse, rel + 6);

        // Random button activity, checked by the scoreboard.
        for (int i = 0; i < 60; i++) begin
            btn = 1'($urandom_range(0, 1));
            step($urandom_range(1, 9));
        end
        btn = 1'b0;
        step(20);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
